// File: rtl/apb_master_ctrl.sv
// AHB-to-APB bridge controller with a posted-write buffer, strict read
// ordering behind buffered writes, and an ACCESS-phase timeout.
//
// state  | meaning
// IDLE   | no APB transfer; Pselx=0, Penable=0
// SETUP  | first APB cycle; Pselx/Paddr/Pwrite/Pwdata driven, Penable=0
// ACCESS | Penable=1, waiting for Pready or timeout
module apb_master_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLV    = 3,
    parameter int WBUF_DEPTH = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [NUM_SLV-1:0] tempselx,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic [NUM_SLV-1:0] Pselx,
    output logic              Hreadyout,
    output logic              Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic              wr_err
);
    localparam int PW = $clog2(WBUF_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state;

    logic [ADDR_W-1:0]  buf_addr [WBUF_DEPTH];
    logic [NUM_SLV-1:0] buf_sel  [WBUF_DEPTH];
    logic [DATA_W-1:0]  buf_data [WBUF_DEPTH];
    logic [PW-1:0]      wptr, rptr;

    logic [ADDR_W-1:0]  wa_addr, rd_addr;
    logic [NUM_SLV-1:0] wa_sel, rd_sel;
    logic               wr_pend, rd_pend, rd_issued, err_hold;
    logic [TW-1:0]      tcnt;

    logic               wr_acc, rd_acc, in_access, tmo, done, xfer_err, pop;
    logic               wr_avail, decide, start_wr, start_rd, room;
    logic [PW-1:0]      count, held, head_ptr, cnt_next;
    logic [ADDR_W-1:0]  head_addr;
    logic [NUM_SLV-1:0] head_sel;
    logic [DATA_W-1:0]  head_data;

    // Next-transfer selection; a write being pushed this cycle is forwarded
    // straight to the APB side when the buffer would otherwise be empty.
    always_comb begin
        wr_acc    = valid & Hreadyout & Hwrite;
        rd_acc    = valid & Hreadyout & ~Hwrite;
        in_access = (state == ACCESS);
        tmo       = in_access & ~Pready & (tcnt == TW'(TIMEOUT - 1));
        done      = in_access & (Pready | tmo);
        xfer_err  = (Pready & Pslverr) | tmo;
        pop       = done & Pwrite;
        count     = wptr - rptr;
        held      = count - PW'(pop);
        head_ptr  = rptr + PW'(pop);
        wr_avail  = (held != '0) | wr_pend;
        decide    = (state == IDLE) | done;
        start_wr  = decide & wr_avail;
        start_rd  = decide & ~wr_avail & rd_pend & ~rd_issued;
        cnt_next  = count + PW'(wr_pend) - PW'(pop);
        room      = (int'(cnt_next) + int'(wr_acc)) < WBUF_DEPTH;
        if (held != '0) begin
            head_addr = buf_addr[head_ptr[PW-2:0]];
            head_sel  = buf_sel[head_ptr[PW-2:0]];
            head_data = buf_data[head_ptr[PW-2:0]];
        end else begin
            head_addr = wa_addr;
            head_sel  = wa_sel;
            head_data = Hwdata;
        end
    end

    // Write buffer storage; pushed in the data phase of an accepted write.
    always_ff @(posedge Hclk) begin
        if (wr_pend) begin
            buf_addr[wptr[PW-2:0]] <= wa_addr;
            buf_sel[wptr[PW-2:0]]  <= wa_sel;
            buf_data[wptr[PW-2:0]] <= Hwdata;
        end
    end

    // AHB capture, buffer pointers, timeout counter, APB FSM and AHB response.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            wa_addr   <= '0;
            wa_sel    <= '0;
            rd_addr   <= '0;
            rd_sel    <= '0;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            rd_issued <= 1'b0;
            err_hold  <= 1'b0;
            tcnt      <= '0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            Pselx     <= '0;
            Hreadyout <= 1'b1;
            Hresp     <= 1'b0;
            Hrdata    <= '0;
            wr_err    <= 1'b0;
        end else begin
            if (valid && Hreadyout) begin
                if (Hwrite) begin
                    wa_addr <= Haddr;
                    wa_sel  <= tempselx;
                end else begin
                    rd_addr <= Haddr;
                    rd_sel  <= tempselx;
                    rd_pend <= 1'b1;
                end
            end
            wr_pend <= wr_acc;
            if (wr_pend) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (pop && xfer_err) wr_err <= 1'b1;

            if (in_access && !done) tcnt <= tcnt + 1'b1;
            else                    tcnt <= '0;

            if (decide) begin
                Penable <= 1'b0;
                if (start_wr) begin
                    state  <= SETUP;
                    Paddr  <= head_addr;
                    Pselx  <= head_sel;
                    Pwdata <= head_data;
                    Pwrite <= 1'b1;
                end else if (start_rd) begin
                    state     <= SETUP;
                    Paddr     <= rd_addr;
                    Pselx     <= rd_sel;
                    Pwrite    <= 1'b0;
                    rd_issued <= 1'b1;
                end else begin
                    state <= IDLE;
                    Pselx <= '0;
                end
            end else if (state == SETUP) begin
                state   <= ACCESS;
                Penable <= 1'b1;
            end

            if (done && !Pwrite) begin
                Hrdata    <= Prdata;
                rd_pend   <= 1'b0;
                rd_issued <= 1'b0;
                if (xfer_err) begin
                    Hresp     <= 1'b1;
                    Hreadyout <= 1'b0;
                    err_hold  <= 1'b1;
                end else begin
                    Hresp     <= 1'b0;
                    Hreadyout <= 1'b1;
                end
            end else if (err_hold) begin
                Hresp     <= 1'b1;
                Hreadyout <= 1'b1;
                err_hold  <= 1'b0;
            end else begin
                Hresp <= 1'b0;
                if (rd_acc || rd_pend) Hreadyout <= 1'b0;
                else                   Hreadyout <= room;
            end
        end
    end
endmodule
